// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the serial DAC writer.
package dac_spi_pkg;

  localparam int FRAME_W   = 24;
  localparam int BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_e;

  localparam logic [3:0] CMD_WRITE        = 4'b0000;
  localparam logic [3:0] CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                     input logic [3:0]  addr,
                                                     input logic [15:0] data);
    return {cmd, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: toggles a registered sclk every CLK_DIV enabled cycles.
// The strobes flag the edge at which sclk is about to rise or fall.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_wrap;

  assign w_wrap     = i_en && (r_cnt == LAST);
  assign o_rise_stb = w_wrap && !r_sclk;
  assign o_fall_stb = w_wrap && r_sclk;
  assign o_sclk     = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI master writing {CMD, ADDR, sample} frames MSB-first to the serial DAC.
// Valid/ready: a sample is taken on any clk edge where din_valid && din_ready.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] CMD       = CMD_WRITE_UPDATE,
  parameter logic [3:0] ADDR      = 4'b0000,
  parameter int         T_CS_IDLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        busy,
  output logic        done,
  output logic        cs,
  output logic        sclk,
  output logic        mosi,
  output state_e      state
);

  localparam int            GW       = (T_CS_IDLE > 1) ? $clog2(T_CS_IDLE) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(T_CS_IDLE - 1);

  state_e                 r_state;
  logic [FRAME_W-1:0]     r_shift;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic                   r_last;
  logic [GW-1:0]          r_gap_cnt;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_cs;
  logic                   w_en;
  logic                   w_clr;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_sclk;
  logic                   w_accept;

  assign w_accept = din_valid && r_ready;
  assign w_en     = (r_state == SETUP) || (r_state == SHIFT);
  // The rise that would start a 25th bit instead closes the frame.
  assign w_clr    = (r_state == SHIFT) && r_last && w_rise;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_en),
    .i_clr      (w_clr),
    .o_sclk     (w_sclk),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
      r_gap_cnt <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cs <= 1'b1;
          if (w_accept) begin
            r_state   <= SETUP;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_cs      <= 1'b0;
            r_shift   <= build_frame(CMD, ADDR, din);
            r_bit_cnt <= '0;
            r_last    <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (w_rise) r_state <= SHIFT;
        end
        SHIFT: begin
          // mosi is r_shift[MSB], so shifting on the falling edge advances it.
          if (w_fall) begin
            if (r_bit_cnt == BIT_CNT_W'(FRAME_W - 1)) begin
              r_last <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
            end
          end else if (w_clr) begin
            r_state   <= GAP;
            r_cs      <= 1'b1;
            r_shift   <= '0;
            r_done    <= 1'b1;
            r_gap_cnt <= '0;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign din_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cs        = r_cs;
  assign sclk      = w_sclk;
  assign mosi      = r_shift[FRAME_W-1];
  assign state     = r_state;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: one instance at CLK_DIV=2/ADDR=0, one at CLK_DIV=1/ADDR=2.
module tb_dac_spi_tx;
  import dac_spi_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        a_rst_n = 1'b1, b_rst_n = 1'b1;
  logic [15:0] a_din = '0, b_din = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, a_busy, a_done, a_cs, a_sclk, a_mosi;
  logic        b_ready, b_busy, b_done, b_cs, b_sclk, b_mosi;
  state_e      a_state, b_state;

  dac_spi_tx #(.CLK_DIV(2), .CMD(4'b0011), .ADDR(4'h0), .T_CS_IDLE(4)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .busy(a_busy), .done(a_done), .cs(a_cs), .sclk(a_sclk), .mosi(a_mosi), .state(a_state)
  );

  dac_spi_tx #(.CLK_DIV(1), .CMD(4'b0011), .ADDR(4'h2), .T_CS_IDLE(4)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .busy(b_busy), .done(b_done), .cs(b_cs), .sclk(b_sclk), .mosi(b_mosi), .state(b_state)
  );

  // scoreboard: {dut index, 24-bit frame}
  logic [24:0] exp_q[$];
  logic [24:0] got;

  logic [1:0]  m_rst, m_cs, m_sclk, m_mosi, m_done;
  assign m_rst  = {b_rst_n, a_rst_n};
  assign m_cs   = {b_cs, a_cs};
  assign m_sclk = {b_sclk, a_sclk};
  assign m_mosi = {b_mosi, a_mosi};
  assign m_done = {b_done, a_done};

  int          div_of [2] = '{2, 1};
  logic [23:0] cap [2];
  int          nbits [2], cs_low [2], rise_gap [2];
  logic        pcs [2], psclk [2], pmosi [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!m_rst[d]) begin
        cap[d] = '0; nbits[d] = 0; cs_low[d] = 0; rise_gap[d] = 0;
        pcs[d] = 1'b1; psclk[d] = 1'b0; pmosi[d] = 1'b0;
      end else begin
        rise_gap[d]++;
        if (!m_cs[d]) cs_low[d]++;
        if (m_sclk[d] && !psclk[d]) begin
          vectors++;
          if (m_mosi[d] !== pmosi[d]) begin
            miscompares++;
            $display("FAIL mosi_stable_at_rise dut%0d: mosi %b, previous cycle %b", d, m_mosi[d], pmosi[d]);
          end
          if (nbits[d] > 0) begin
            vectors++;
            if (rise_gap[d] != 2 * div_of[d]) begin
              miscompares++;
              $display("FAIL sclk_period dut%0d: got %0d cycles, expected %0d", d, rise_gap[d], 2 * div_of[d]);
            end
          end
          rise_gap[d] = 0;
          cap[d] = {cap[d][22:0], m_mosi[d]};
          nbits[d]++;
        end
        if (m_done[d]) begin
          vectors++;
          if (!(m_cs[d] && !pcs[d])) begin
            miscompares++;
            $display("FAIL done_position dut%0d: done high while cs %b (prev %b), expected cs rising", d, m_cs[d], pcs[d]);
          end
        end
        if (m_cs[d] && !pcs[d]) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL frame_unexpected dut%0d: got %h, expected no frame", d, cap[d]);
          end else begin
            got = exp_q.pop_front();
            if ({1'(d), cap[d]} !== got) begin
              miscompares++;
              $display("FAIL frame_data dut%0d: got %h, expected %h", d, {1'(d), cap[d]}, got);
            end
          end
          vectors++;
          if (nbits[d] != 24) begin
            miscompares++;
            $display("FAIL rise_count dut%0d: got %0d, expected 24", d, nbits[d]);
          end
          vectors++;
          if (cs_low[d] != 49 * div_of[d]) begin
            miscompares++;
            $display("FAIL cs_low_cycles dut%0d: got %0d, expected %0d", d, cs_low[d], 49 * div_of[d]);
          end
          vectors++;
          if (m_done[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL done_at_cs_rise dut%0d: got %b, expected 1", d, m_done[d]);
          end
          cap[d] = '0; nbits[d] = 0; cs_low[d] = 0;
        end
        pcs[d] = m_cs[d]; psclk[d] = m_sclk[d]; pmosi[d] = m_mosi[d];
      end
    end
  end

  // driver tasks
  task automatic send_word(input int d, input logic [15:0] data, input bit expect_frame, input bit hold);
    int t = 0;
    @(negedge clk);
    if (d == 0) begin a_din = data; a_valid = 1'b1; end
    else        begin b_din = data; b_valid = 1'b1; end
    while (((d == 0) ? a_ready : b_ready) !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout dut%0d: din_ready 0 after %0d cycles, expected 1", d, t);
    end else begin
      if (expect_frame)
        exp_q.push_back({1'(d), 4'h3, (d == 0) ? 4'h0 : 4'h2, data});
      @(posedge clk);
      #1;
      if (!hold) begin
        if (d == 0) a_valid = 1'b0; else b_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int d);
    int t = 0;
    @(negedge clk);
    while (!(((d == 0) ? a_ready : b_ready) === 1'b1 && ((d == 0) ? a_busy : b_busy) === 1'b0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 600) begin
      miscompares++;
      $display("FAIL idle_timeout dut%0d: not idle after %0d cycles, expected idle", d, t);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL frames_outstanding dut%0d: got %0d pending, expected 0", d, exp_q.size());
      exp_q.delete();
    end
  endtask

  // tests
  task automatic test_reset();
    #2;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 8;
    if (a_cs !== 1'b1)    begin miscompares++; $display("FAIL reset_cs: got %b, expected 1", a_cs); end
    if (a_sclk !== 1'b0)  begin miscompares++; $display("FAIL reset_sclk: got %b, expected 0", a_sclk); end
    if (a_mosi !== 1'b0)  begin miscompares++; $display("FAIL reset_mosi: got %b, expected 0", a_mosi); end
    if (a_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, expected 0", a_ready); end
    if (a_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", a_busy); end
    if (a_done !== 1'b0)  begin miscompares++; $display("FAIL reset_done: got %b, expected 0", a_done); end
    if (a_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d, expected IDLE", a_state); end
    if (b_cs !== 1'b1)    begin miscompares++; $display("FAIL reset_cs_b: got %b, expected 1", b_cs); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (a_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_release: got %b, expected 1", a_ready); end
    if (b_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_release_b: got %b, expected 1", b_ready); end
  endtask

  task automatic test_basic_frame();
    send_word(0, 16'hA5C3, 1'b1, 1'b0);
    wait_idle(0);
  endtask

  task automatic test_back_to_back();
    int t = 0;
    int g = 0;
    send_word(0, 16'h0001, 1'b1, 1'b1);
    a_din = 16'hFFFF;
    exp_q.push_back({1'b0, 4'h3, 4'h0, 16'hFFFF});
    while (a_cs !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    while (a_cs !== 1'b0 && g < 400) begin @(negedge clk); g++; end
    a_valid = 1'b0;
    vectors++;
    if (g != 5) begin
      miscompares++;
      $display("FAIL handshake_delay: got %0d cycles after cs rise, expected 5", g);
    end
    vectors++;
    if (g < 4) begin
      miscompares++;
      $display("FAIL cs_high_gap: got %0d cycles, expected >= 4", g);
    end
    wait_idle(0);
  endtask

  task automatic test_ignored_while_busy();
    send_word(0, 16'h5A5A, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      a_din   = 16'($urandom_range(0, 65535));
      a_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (a_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_while_busy: got %b, expected 0", a_ready);
      end
    end
    a_valid = 1'b0;
    wait_idle(0);
  endtask

  task automatic test_reset_mid_frame();
    int   rises = 0;
    int   t = 0;
    logic prev = 1'b0;
    send_word(0, 16'hBEEF, 1'b0, 1'b0);
    while (rises < 10 && t < 400) begin
      @(negedge clk);
      if (a_sclk && !prev) rises++;
      prev = a_sclk;
      t++;
    end
    a_rst_n = 1'b0;
    #1;
    vectors += 3;
    if (a_cs !== 1'b1)    begin miscompares++; $display("FAIL midreset_cs: got %b, expected 1", a_cs); end
    if (a_sclk !== 1'b0)  begin miscompares++; $display("FAIL midreset_sclk: got %b, expected 0", a_sclk); end
    if (a_state !== IDLE) begin miscompares++; $display("FAIL midreset_state: got %0d, expected IDLE", a_state); end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (a_done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b, expected 0", a_done); end
    end
    a_rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (a_done !== 1'b0) begin miscompares++; $display("FAIL postreset_done: got %b, expected 0", a_done); end
    end
    send_word(0, 16'h1234, 1'b1, 1'b0);
    wait_idle(0);
  endtask

  task automatic test_clk_div1();
    send_word(1, 16'h0000, 1'b1, 1'b0);
    wait_idle(1);
    send_word(1, 16'hFFFF, 1'b1, 1'b0);
    wait_idle(1);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_ignored_while_busy();
    test_reset_mid_frame();
    test_clk_div1();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
